// File: rtl/ysyx_bus_arb_if.sv
// Bundle of every request/response wire around the bus arbiter.
// The arbiter takes the 'slave' view: it is the target of the IFU/LSU
// requests and of the memory responses, and drives the rest. The 'master'
// view is the surrounding system (fetch unit, load/store unit, memory).
interface ysyx_bus_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU read channel
  logic [ADDR_W-1:0]   ifu_araddr;
  logic                ifu_arvalid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_rvalid;
  logic                ifu_err;
  // LSU read/write channels
  logic [ADDR_W-1:0]   lsu_araddr;
  logic                lsu_arvalid;
  logic [ADDR_W-1:0]   lsu_awaddr;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb;
  logic                lsu_wvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_rvalid;
  logic                lsu_bvalid;
  logic                lsu_err;
  // Shared memory port
  logic [ADDR_W-1:0]   mem_araddr;
  logic                mem_arvalid;
  logic [ADDR_W-1:0]   mem_awaddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_wvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rvalid;
  logic                mem_bvalid;

  modport slave (
    input  ifu_araddr, ifu_arvalid,
    output ifu_rdata, ifu_rvalid, ifu_err,
    input  lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_wvalid,
    output lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
    output mem_araddr, mem_arvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_wvalid,
    input  mem_rdata, mem_rvalid, mem_bvalid
  );

  modport master (
    output ifu_araddr, ifu_arvalid,
    input  ifu_rdata, ifu_rvalid, ifu_err,
    output lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_wvalid,
    input  lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
    input  mem_araddr, mem_arvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_wvalid,
    output mem_rdata, mem_rvalid, mem_bvalid
  );
endinterface

// File: rtl/ysyx_bus_arb.sv
// Two-master (IFU, LSU) to one-memory bus arbiter. One transaction in
// flight at a time, round-robin between IFU and LSU, LSU writes before LSU
// reads, and a wait counter that turns a silent memory into an error reply.
module ysyx_bus_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active low
  ysyx_bus_arb_if.slave  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;
  typedef enum logic {GNT_IFU, GNT_LSU} grant_t;

  state_t              state, state_nxt;
  grant_t              last_grant;
  logic [7:0]          wait_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic                gnt_ifu, gnt_lsu;
  logic                lsu_req;
  logic                resp;      // real memory response for the current state
  logic                timeout;   // counter reached its limit this cycle

  // The memory side always sees the holding registers, never live master inputs.
  assign bus.mem_araddr = addr_q;
  assign bus.mem_awaddr = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant bookkeeping, holding registers and the wait counter.
  // NOTE: holding registers are plain flops driving mem_* directly, so they get a reset value too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_IFU;
      wait_cnt   <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else if (gnt_ifu) begin
      last_grant <= GNT_IFU;
      wait_cnt   <= 8'd0;
      addr_q     <= bus.ifu_araddr;
    end else if (gnt_lsu) begin
      last_grant <= GNT_LSU;
      wait_cnt   <= 8'd0;
      addr_q     <= bus.lsu_wvalid ? bus.lsu_awaddr : bus.lsu_araddr;
      wdata_q    <= bus.lsu_wdata;
      wstrb_q    <= bus.lsu_wstrb;
    end else if (state != IDLE && !resp && !timeout) begin
      wait_cnt   <= wait_cnt + 8'd1;
    end
  end

  // Arbitration, next state and all handshake outputs.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    gnt_ifu         = 1'b0;
    gnt_lsu         = 1'b0;
    lsu_req         = bus.lsu_wvalid | bus.lsu_arvalid;
    resp            = 1'b0;
    timeout         = (wait_cnt == TIMEOUT_CNT);
    bus.mem_arvalid = 1'b0;
    bus.mem_wvalid  = 1'b0;
    bus.ifu_rdata   = '0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_err     = 1'b0;
    bus.lsu_rdata   = '0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_bvalid  = 1'b0;
    bus.lsu_err     = 1'b0;

    case (state)
      IDLE: begin
        // On conflict the master that did not win last time gets the bus.
        if (bus.ifu_arvalid && lsu_req) begin
          if (last_grant == GNT_IFU) gnt_lsu = 1'b1;
          else                       gnt_ifu = 1'b1;
        end else if (bus.ifu_arvalid) begin
          gnt_ifu = 1'b1;
        end else if (lsu_req) begin
          gnt_lsu = 1'b1;
        end
        if (gnt_ifu)      state_nxt = IFU_RD;
        else if (gnt_lsu) state_nxt = bus.lsu_wvalid ? LSU_WR : LSU_RD;
      end

      IFU_RD: begin
        bus.mem_arvalid = 1'b1;
        resp            = bus.mem_rvalid;
        bus.ifu_rvalid  = resp | timeout;
        bus.ifu_err     = timeout & ~resp;
        bus.ifu_rdata   = (timeout && !resp) ? '0 : bus.mem_rdata;
        if (resp || timeout) state_nxt = IDLE;
      end

      LSU_RD: begin
        bus.mem_arvalid = 1'b1;
        resp            = bus.mem_rvalid;
        bus.lsu_rvalid  = resp | timeout;
        bus.lsu_err     = timeout & ~resp;
        bus.lsu_rdata   = (timeout && !resp) ? '0 : bus.mem_rdata;
        if (resp || timeout) state_nxt = IDLE;
      end

      LSU_WR: begin
        bus.mem_wvalid  = 1'b1;
        resp            = bus.mem_bvalid;
        bus.lsu_bvalid  = resp | timeout;
        bus.lsu_err     = timeout & ~resp;
        if (resp || timeout) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
